// File: rtl/ray_pkg.sv
// Shared types and constants for the ray-cast column scheduler and its
// nearest-hit selector.
package ray_pkg;

   localparam int ANGLE_W     = 12;
   localparam int COORD_W     = 12;
   localparam int FULL_CIRCLE = 1 << ANGLE_W;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_SELECT = 3'd3,
      S_EMIT   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   // Manhattan distance; one extra bit so the sum of two full-range deltas fits.
   function automatic logic [COORD_W:0] manhattan(input logic [COORD_W-1:0] ax,
                                                  input logic [COORD_W-1:0] ay,
                                                  input logic [COORD_W-1:0] bx,
                                                  input logic [COORD_W-1:0] by);
      return {1'b0, abs_diff(ax, bx)} + {1'b0, abs_diff(ay, by)};
   endfunction

endpackage

// File: rtl/nearer_hit_select.sv
// Picks the nearer of the horizontal and vertical wall hits for one ray.
// Purely combinational; the scheduler registers the result.
module nearer_hit_select
   import ray_pkg::*;
(
   input  logic [COORD_W-1:0] ray_x,
   input  logic [COORD_W-1:0] ray_y,
   input  logic [COORD_W-1:0] h_x,
   input  logic [COORD_W-1:0] h_y,
   input  logic               h_found,
   input  logic [COORD_W-1:0] v_x,
   input  logic [COORD_W-1:0] v_y,
   input  logic               v_found,
   output logic [COORD_W-1:0] sel_x,
   output logic [COORD_W-1:0] sel_y,
   output logic [COORD_W:0]   sel_dist,
   output logic               sel_found,
   output logic               sel_horiz
);

   logic [COORD_W:0] h_dist;
   logic [COORD_W:0] v_dist;

   assign h_dist = manhattan(h_x, h_y, ray_x, ray_y);
   assign v_dist = manhattan(v_x, v_y, ray_x, ray_y);

   // Equal distances resolve to the horizontal finder.
   always_comb begin
      sel_x     = '0;
      sel_y     = '0;
      sel_dist  = '1;
      sel_found = 1'b0;
      sel_horiz = 1'b0;
      if (h_found && (!v_found || (h_dist <= v_dist))) begin
         sel_x     = h_x;
         sel_y     = h_y;
         sel_dist  = h_dist;
         sel_found = 1'b1;
         sel_horiz = 1'b1;
      end else if (v_found) begin
         sel_x     = v_x;
         sel_y     = v_y;
         sel_dist  = v_dist;
         sel_found = 1'b1;
      end
   end

endmodule

// File: rtl/raycast_column_scheduler.sv
// Frame sequencer: sweeps every screen column, launches both wall finders per
// ray, and hands the nearer hit to the column renderer one column at a time.
module raycast_column_scheduler
   import ray_pkg::*;
#(
   parameter int NUM_COLS   = 160,
   parameter int ANGLE_STEP = 4
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               start_frame,
   input  logic [COORD_W-1:0] playerX,
   input  logic [COORD_W-1:0] playerY,
   input  logic [ANGLE_W-1:0] player_angle,
   output logic [ANGLE_W-1:0] alpha,
   output logic [COORD_W-1:0] rayX,
   output logic [COORD_W-1:0] rayY,
   output logic               begin_calc,
   input  logic [COORD_W-1:0] h_wallX,
   input  logic [COORD_W-1:0] h_wallY,
   input  logic               h_wall_found,
   input  logic               h_end_calc,
   input  logic [COORD_W-1:0] v_wallX,
   input  logic [COORD_W-1:0] v_wallY,
   input  logic               v_wall_found,
   input  logic               v_end_calc,
   output logic [7:0]         col_idx,
   output logic [COORD_W-1:0] hitX,
   output logic [COORD_W-1:0] hitY,
   output logic [COORD_W:0]   hit_dist,
   output logic               hit_found,
   output logic               hit_horiz,
   output logic               col_valid,
   input  logic               col_ready,
   output logic               frame_busy,
   output logic               frame_done,
   output logic [2:0]         state_dbg
);

   // Column handshake: a result transfers on any rising edge where col_valid
   // and col_ready are both high. While col_valid is high and col_ready is
   // low, col_idx, hitX, hitY, hit_dist, hit_found and hit_horiz hold steady.
   // col_ready may stay low for any number of cycles.

   localparam logic [ANGLE_W-1:0] HALF_SWEEP =
      ANGLE_W'(((NUM_COLS * ANGLE_STEP) / 2) % FULL_CIRCLE);
   localparam logic [ANGLE_W-1:0] STEP     = ANGLE_W'(ANGLE_STEP % FULL_CIRCLE);
   localparam logic [7:0]         LAST_COL = 8'(NUM_COLS - 1);

   state_t             state;
   logic [7:0]         col;
   logic               h_done;
   logic               v_done;
   logic [COORD_W-1:0] h_x_q;
   logic [COORD_W-1:0] h_y_q;
   logic               h_found_q;
   logic [COORD_W-1:0] v_x_q;
   logic [COORD_W-1:0] v_y_q;
   logic               v_found_q;
   logic               both_done;

   logic [COORD_W-1:0] sel_x;
   logic [COORD_W-1:0] sel_y;
   logic [COORD_W:0]   sel_dist;
   logic               sel_found;
   logic               sel_horiz;

   assign state_dbg = state;
   assign col_idx   = col;
   // Count a pulse arriving this cycle so the last done reaches S_SELECT at once.
   assign both_done = (h_done | h_end_calc) & (v_done | v_end_calc);

   nearer_hit_select u_select (
      .ray_x     (rayX),
      .ray_y     (rayY),
      .h_x       (h_x_q),
      .h_y       (h_y_q),
      .h_found   (h_found_q),
      .v_x       (v_x_q),
      .v_y       (v_y_q),
      .v_found   (v_found_q),
      .sel_x     (sel_x),
      .sel_y     (sel_y),
      .sel_dist  (sel_dist),
      .sel_found (sel_found),
      .sel_horiz (sel_horiz)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state      <= S_IDLE;
         col        <= '0;
         alpha      <= '0;
         rayX       <= '0;
         rayY       <= '0;
         begin_calc <= 1'b0;
         h_done     <= 1'b0;
         v_done     <= 1'b0;
         h_x_q      <= '0;
         h_y_q      <= '0;
         h_found_q  <= 1'b0;
         v_x_q      <= '0;
         v_y_q      <= '0;
         v_found_q  <= 1'b0;
         hitX       <= '0;
         hitY       <= '0;
         hit_dist   <= '0;
         hit_found  <= 1'b0;
         hit_horiz  <= 1'b0;
         col_valid  <= 1'b0;
         frame_busy <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_frame) begin
                  rayX       <= playerX;
                  rayY       <= playerY;
                  alpha      <= player_angle - HALF_SWEEP;
                  col        <= '0;
                  begin_calc <= 1'b1;
                  frame_busy <= 1'b1;
                  state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               begin_calc <= 1'b0;
               h_done     <= 1'b0;
               v_done     <= 1'b0;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               if (h_end_calc && !h_done) begin
                  h_done    <= 1'b1;
                  h_x_q     <= h_wallX;
                  h_y_q     <= h_wallY;
                  h_found_q <= h_wall_found;
               end
               if (v_end_calc && !v_done) begin
                  v_done    <= 1'b1;
                  v_x_q     <= v_wallX;
                  v_y_q     <= v_wallY;
                  v_found_q <= v_wall_found;
               end
               if (both_done) begin
                  state <= S_SELECT;
               end
            end
            S_SELECT: begin
               hitX      <= sel_x;
               hitY      <= sel_y;
               hit_dist  <= sel_dist;
               hit_found <= sel_found;
               hit_horiz <= sel_horiz;
               col_valid <= 1'b1;
               state     <= S_EMIT;
            end
            S_EMIT: begin
               if (col_ready) begin
                  col_valid <= 1'b0;
                  if (col == LAST_COL) begin
                     frame_done <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     col        <= col + 8'd1;
                     alpha      <= alpha + STEP;
                     begin_calc <= 1'b1;
                     state      <= S_LAUNCH;
                  end
               end
            end
            S_DONE: begin
               frame_done <= 1'b0;
               frame_busy <= 1'b0;
               state      <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_raycast_column_scheduler.sv
// Directed bench for raycast_column_scheduler with a 4-column sweep and the
// two wall finders played by the bench.
module tb_raycast_column_scheduler;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        start_frame = 1'b0;
   logic [11:0] playerX = '0;
   logic [11:0] playerY = '0;
   logic [11:0] player_angle = '0;
   logic [11:0] alpha;
   logic [11:0] rayX;
   logic [11:0] rayY;
   logic        begin_calc;
   logic [11:0] h_wallX = '0;
   logic [11:0] h_wallY = '0;
   logic        h_wall_found = 1'b0;
   logic        h_end_calc = 1'b0;
   logic [11:0] v_wallX = '0;
   logic [11:0] v_wallY = '0;
   logic        v_wall_found = 1'b0;
   logic        v_end_calc = 1'b0;
   logic [7:0]  col_idx;
   logic [11:0] hitX;
   logic [11:0] hitY;
   logic [12:0] hit_dist;
   logic        hit_found;
   logic        hit_horiz;
   logic        col_valid;
   logic        col_ready = 1'b1;
   logic        frame_busy;
   logic        frame_done;
   logic [2:0]  state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   int bc_cnt   = 0;
   int fd_cnt   = 0;

   raycast_column_scheduler #(.NUM_COLS(4), .ANGLE_STEP(4)) dut (
      .clock        (clock),
      .resetn       (resetn),
      .start_frame  (start_frame),
      .playerX      (playerX),
      .playerY      (playerY),
      .player_angle (player_angle),
      .alpha        (alpha),
      .rayX         (rayX),
      .rayY         (rayY),
      .begin_calc   (begin_calc),
      .h_wallX      (h_wallX),
      .h_wallY      (h_wallY),
      .h_wall_found (h_wall_found),
      .h_end_calc   (h_end_calc),
      .v_wallX      (v_wallX),
      .v_wallY      (v_wallY),
      .v_wall_found (v_wall_found),
      .v_end_calc   (v_end_calc),
      .col_idx      (col_idx),
      .hitX         (hitX),
      .hitY         (hitY),
      .hit_dist     (hit_dist),
      .hit_found    (hit_found),
      .hit_horiz    (hit_horiz),
      .col_valid    (col_valid),
      .col_ready    (col_ready),
      .frame_busy   (frame_busy),
      .frame_done   (frame_done),
      .state_dbg    (state_dbg)
   );

   always #10 clock = ~clock;

   always @(negedge clock) begin
      if (begin_calc === 1'b1) bc_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start(input logic [11:0] px, input logic [11:0] py, input logic [11:0] ang);
      playerX      = px;
      playerY      = py;
      player_angle = ang;
      start_frame  = 1'b1;
      tick();
      start_frame  = 1'b0;
   endtask

   // Plays both finders for one column and returns what the DUT presented.
   // v_dup >= 0 adds a second v pulse with corrupted data that must be ignored.
   task automatic serve_column(
      input  logic [11:0] hx, input logic [11:0] hy, input logic hf,
      input  logic [11:0] vx, input logic [11:0] vy, input logic vf,
      input  int h_dly, input int v_dly, input int v_dup,
      output logic ok, output logic [11:0] a_o, output logic [7:0] i_o,
      output logic [11:0] x_o, output logic [11:0] y_o, output logic [12:0] d_o,
      output logic f_o, output logic hz_o, output int lat_o);
      int n;
      int last;
      ok = 1'b1;
      n  = 0;
      while (begin_calc !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      if (begin_calc !== 1'b1) ok = 1'b0;
      a_o = alpha;
      tick();
      last = (h_dly > v_dly) ? h_dly : v_dly;
      for (int t = 0; t <= last; t++) begin
         h_end_calc   = (t == h_dly);
         h_wallX      = hx;
         h_wallY      = hy;
         h_wall_found = hf;
         v_end_calc   = (t == v_dly) || (t == v_dup);
         v_wallX      = (t == v_dup) ? hx + 12'd7 : vx;
         v_wallY      = (t == v_dup) ? hy + 12'd7 : vy;
         v_wall_found = (t == v_dup) ? ~vf : vf;
         tick();
      end
      h_end_calc = 1'b0;
      v_end_calc = 1'b0;
      lat_o = 1;
      while (col_valid !== 1'b1 && lat_o < 60) begin
         tick();
         lat_o++;
      end
      if (col_valid !== 1'b1) ok = 1'b0;
      i_o  = col_idx;
      x_o  = hitX;
      y_o  = hitY;
      d_o  = hit_dist;
      f_o  = hit_found;
      hz_o = hit_horiz;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({frame_busy, col_valid, begin_calc, frame_done, hit_found, hit_horiz} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags: busy=%b valid=%b bc=%b done=%b found=%b horiz=%b, required all 0",
                  frame_busy, col_valid, begin_calc, frame_done, hit_found, hit_horiz);
      end
      n_checks++;
      if (alpha !== 12'd0 || rayX !== 12'd0 || hit_dist !== 13'd0 || col_idx !== 8'd0 || state_dbg !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_values: alpha=%0d rayX=%0d dist=%0d idx=%0d state=%0d, required 0",
                  alpha, rayX, hit_dist, col_idx, state_dbg);
      end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_frame_basic();
      logic ok; logic [11:0] a; logic [7:0] i; logic [11:0] x, y; logic [12:0] d;
      logic f, hz; int lat; int bc0; int fd0;
      logic [11:0] exp_a [4];
      exp_a = '{12'd92, 12'd96, 12'd100, 12'd104};
      bc0 = bc_cnt;
      fd0 = fd_cnt;
      start(12'd100, 12'd100, 12'd100);
      n_checks++;
      if (frame_busy !== 1'b1 || begin_calc !== 1'b1 || rayX !== 12'd100 || rayY !== 12'd100) begin
         n_fail++;
         $display("FAIL start_launch: busy=%b bc=%b rayX=%0d rayY=%0d, required 1 1 100 100",
                  frame_busy, begin_calc, rayX, rayY);
      end
      // v finishes 5 cycles ahead of h, then pulses again with junk
      serve_column(12'd100, 12'd164, 1'b1, 12'd140, 12'd100, 1'b1, 6, 1, 3, ok, a, i, x, y, d, f, hz, lat);
      n_checks++;
      if (!ok || a !== exp_a[0] || i !== 8'd0 || x !== 12'd140 || y !== 12'd100 || d !== 13'd40 || f !== 1'b1 || hz !== 1'b0) begin
         n_fail++;
         $display("FAIL v_first: ok=%b alpha=%0d idx=%0d hit=(%0d,%0d) dist=%0d found=%b horiz=%b, required 1 92 0 (140,100) 40 1 0",
                  ok, a, i, x, y, d, f, hz);
      end
      n_checks++;
      if (lat !== 2) begin
         n_fail++;
         $display("FAIL latency_v_first: got %0d cycles, required 2", lat);
      end
      start_frame  = 1'b1;
      playerX      = 12'd999;
      player_angle = 12'd0;
      serve_column(12'd100, 12'd164, 1'b1, 12'd140, 12'd100, 1'b1, 1, 1, -1, ok, a, i, x, y, d, f, hz, lat);
      start_frame  = 1'b0;
      n_checks++;
      if (!ok || a !== exp_a[1] || i !== 8'd1 || x !== 12'd140 || d !== 13'd40 || hz !== 1'b0 || lat !== 2) begin
         n_fail++;
         $display("FAIL same_cycle: ok=%b alpha=%0d idx=%0d hitX=%0d dist=%0d horiz=%b lat=%0d, required 1 96 1 140 40 0 2",
                  ok, a, i, x, d, hz, lat);
      end
      n_checks++;
      if (rayX !== 12'd100) begin
         n_fail++;
         $display("FAIL snapshot_hold: rayX=%0d, required 100", rayX);
      end
      serve_column(12'd132, 12'd100, 1'b1, 12'd100, 12'd132, 1'b1, 2, 3, -1, ok, a, i, x, y, d, f, hz, lat);
      n_checks++;
      if (!ok || a !== exp_a[2] || i !== 8'd2 || x !== 12'd132 || y !== 12'd100 || d !== 13'd32 || hz !== 1'b1 || f !== 1'b1) begin
         n_fail++;
         $display("FAIL tie_horiz: ok=%b alpha=%0d idx=%0d hit=(%0d,%0d) dist=%0d horiz=%b found=%b, required 1 100 2 (132,100) 32 1 1",
                  ok, a, i, x, y, d, hz, f);
      end
      serve_column(12'd50, 12'd60, 1'b0, 12'd100, 12'd90, 1'b1, 2, 2, -1, ok, a, i, x, y, d, f, hz, lat);
      n_checks++;
      if (!ok || a !== exp_a[3] || i !== 8'd3 || x !== 12'd100 || y !== 12'd90 || d !== 13'd10 || f !== 1'b1 || hz !== 1'b0) begin
         n_fail++;
         $display("FAIL only_v: ok=%b alpha=%0d idx=%0d hit=(%0d,%0d) dist=%0d found=%b horiz=%b, required 1 104 3 (100,90) 10 1 0",
                  ok, a, i, x, y, d, f, hz);
      end
      tick();
      n_checks++;
      if (frame_done !== 1'b1 || col_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_done_pulse: done=%b valid=%b, required 1 0", frame_done, col_valid);
      end
      tick();
      n_checks++;
      if (frame_done !== 1'b0 || frame_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_end_idle: done=%b busy=%b, required 0 0", frame_done, frame_busy);
      end
      n_checks++;
      if (bc_cnt - bc0 !== 4 || fd_cnt - fd0 !== 1) begin
         n_fail++;
         $display("FAIL pulse_counts: begin_calc=%0d frame_done=%0d, required 4 1", bc_cnt - bc0, fd_cnt - fd0);
      end
   endtask

   task automatic test_wrap_miss();
      logic ok; logic [11:0] a; logic [7:0] i; logic [11:0] x, y; logic [12:0] d;
      logic f, hz; int lat;
      logic [11:0] exp_a [4];
      exp_a = '{12'd4090, 12'd4094, 12'd2, 12'd6};
      start(12'd100, 12'd100, 12'd2);
      serve_column(12'd10, 12'd10, 1'b0, 12'd20, 12'd20, 1'b0, 1, 2, -1, ok, a, i, x, y, d, f, hz, lat);
      n_checks++;
      if (!ok || a !== exp_a[0] || x !== 12'd0 || y !== 12'd0 || d !== 13'd8191 || f !== 1'b0 || hz !== 1'b0) begin
         n_fail++;
         $display("FAIL both_miss: ok=%b alpha=%0d hit=(%0d,%0d) dist=%0d found=%b horiz=%b, required 1 4090 (0,0) 8191 0 0",
                  ok, a, x, y, d, f, hz);
      end
      for (int c = 1; c < 4; c++) begin
         serve_column(12'd100, 12'd110, 1'b1, 12'd120, 12'd100, 1'b1, 1, 2, -1, ok, a, i, x, y, d, f, hz, lat);
         n_checks++;
         if (!ok || a !== exp_a[c] || i !== 8'(c) || x !== 12'd100 || y !== 12'd110 || d !== 13'd10 || hz !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_col%0d: ok=%b alpha=%0d idx=%0d hit=(%0d,%0d) dist=%0d horiz=%b, required 1 %0d %0d (100,110) 10 1",
                     c, ok, a, i, x, y, d, hz, exp_a[c], c);
         end
      end
      tick();
      n_checks++;
      if (frame_done !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_frame_done: done=%b, required 1", frame_done);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic ok; logic [11:0] a; logic [7:0] i; logic [11:0] x, y; logic [12:0] d;
      logic f, hz; int lat;
      col_ready = 1'b0;
      start(12'd100, 12'd100, 12'd100);
      serve_column(12'd100, 12'd110, 1'b1, 12'd120, 12'd100, 1'b1, 2, 1, -1, ok, a, i, x, y, d, f, hz, lat);
      n_checks++;
      if (!ok || a !== 12'd92 || i !== 8'd0 || d !== 13'd10) begin
         n_fail++;
         $display("FAIL bp_first: ok=%b alpha=%0d idx=%0d dist=%0d, required 1 92 0 10", ok, a, i, d);
      end
      for (int k = 0; k < 20; k++) begin
         tick();
         n_checks++;
         if (col_valid !== 1'b1 || begin_calc !== 1'b0 || hitX !== 12'd100 || hitY !== 12'd110 ||
             hit_dist !== 13'd10 || col_idx !== 8'd0 || hit_horiz !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold%0d: valid=%b bc=%b hit=(%0d,%0d) dist=%0d idx=%0d horiz=%b, required 1 0 (100,110) 10 0 1",
                     k, col_valid, begin_calc, hitX, hitY, hit_dist, col_idx, hit_horiz);
         end
      end
      col_ready = 1'b1;
      tick();
      n_checks++;
      if (begin_calc !== 1'b1 || col_valid !== 1'b0 || col_idx !== 8'd1 || alpha !== 12'd96) begin
         n_fail++;
         $display("FAIL bp_release: bc=%b valid=%b idx=%0d alpha=%0d, required 1 0 1 96",
                  begin_calc, col_valid, col_idx, alpha);
      end
      for (int c = 1; c < 4; c++) begin
         serve_column(12'd100, 12'd110, 1'b1, 12'd120, 12'd100, 1'b1, 1, 1, -1, ok, a, i, x, y, d, f, hz, lat);
      end
      tick();
      n_checks++;
      if (frame_done !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_frame_done: done=%b, required 1", frame_done);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic ok; logic [11:0] a; logic [7:0] i; logic [11:0] x, y; logic [12:0] d;
      logic f, hz; int lat; int fd0;
      start(12'd300, 12'd200, 12'd100);
      for (int c = 0; c < 2; c++) begin
         serve_column(12'd300, 12'd210, 1'b1, 12'd320, 12'd200, 1'b1, 1, 1, -1, ok, a, i, x, y, d, f, hz, lat);
      end
      tick();
      n_checks++;
      if (begin_calc !== 1'b1 || col_idx !== 8'd2) begin
         n_fail++;
         $display("FAIL mid_launch: bc=%b idx=%0d, required 1 2", begin_calc, col_idx);
      end
      repeat (2) tick();
      fd0 = fd_cnt;
      resetn = 1'b0;
      tick();
      n_checks++;
      if ({frame_busy, col_valid, begin_calc, frame_done, hit_found, hit_horiz} !== 6'b0 ||
          alpha !== 12'd0 || rayX !== 12'd0 || rayY !== 12'd0 || col_idx !== 8'd0 ||
          hitX !== 12'd0 || hit_dist !== 13'd0 || state_dbg !== 3'd0) begin
         n_fail++;
         $display("FAIL mid_reset: busy=%b valid=%b bc=%b alpha=%0d rayX=%0d idx=%0d hitX=%0d dist=%0d state=%0d, required all 0",
                  frame_busy, col_valid, begin_calc, alpha, rayX, col_idx, hitX, hit_dist, state_dbg);
      end
      resetn = 1'b1;
      repeat (5) tick();
      n_checks++;
      if (fd_cnt !== fd0 || frame_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL no_partial_done: frame_done pulses=%0d busy=%b, required 0 0", fd_cnt - fd0, frame_busy);
      end
      start(12'd100, 12'd100, 12'd2);
      serve_column(12'd100, 12'd110, 1'b1, 12'd120, 12'd100, 1'b1, 1, 1, -1, ok, a, i, x, y, d, f, hz, lat);
      n_checks++;
      if (!ok || i !== 8'd0 || a !== 12'd4090 || rayX !== 12'd100 || d !== 13'd10) begin
         n_fail++;
         $display("FAIL restart_col0: ok=%b idx=%0d alpha=%0d rayX=%0d dist=%0d, required 1 0 4090 100 10",
                  ok, i, a, rayX, d);
      end
      for (int c = 1; c < 4; c++) begin
         serve_column(12'd100, 12'd110, 1'b1, 12'd120, 12'd100, 1'b1, 1, 1, -1, ok, a, i, x, y, d, f, hz, lat);
      end
      tick();
      n_checks++;
      if (frame_done !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_frame_done: done=%b, required 1", frame_done);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_frame_basic();
      test_wrap_miss();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
